// File: rtl/acc_tile_pkg.sv
// Shared types and helpers for the accumulating tile buffer.
// The saturating add helper is used only when ACC_SAT_EN is defined.
package acc_tile_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ACCUM = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam int DEF_DATA_W = 16;
    localparam int SAT_MAX_W  = 64;

    typedef struct packed {
        logic [SAT_MAX_W-1:0] sum;
        logic                 clip;
    } sat_res_t;

    // Operands arrive sign-extended to SAT_MAX_W; w is the real element width.
    function automatic sat_res_t sat_add(input logic [SAT_MAX_W-1:0] a,
                                         input logic [SAT_MAX_W-1:0] b,
                                         input int unsigned           w);
        sat_res_t                    res;
        logic signed [SAT_MAX_W-1:0] sum_s;
        logic signed [SAT_MAX_W-1:0] hi_s;
        logic signed [SAT_MAX_W-1:0] lo_s;
        sum_s = $signed(a) + $signed(b);
        hi_s  = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
        lo_s  = -(64'sd1 <<< (w - 32'd1));
        if (sum_s > hi_s) begin
            res.sum  = hi_s;
            res.clip = 1'b1;
        end else if (sum_s < lo_s) begin
            res.sum  = lo_s;
            res.clip = 1'b1;
        end else begin
            res.sum  = sum_s;
            res.clip = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/acc_tile_buffer_lane_add.sv
// Per-lane signed adder: saturating when ACC_SAT_EN is defined,
// otherwise wrapping modulo 2^DATA_W with clip_o held low.
module acc_lane_add
    import acc_tile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] sum_o,
    output logic              clip_o
);

`ifdef ACC_SAT_EN
    sat_res_t res_s;
    logic     unused_hi_s;

    // Sign-extend into the helper's working width and clip back down.
    always_comb begin
        res_s  = sat_add({{(SAT_MAX_W-DATA_W){a_i[DATA_W-1]}}, a_i},
                         {{(SAT_MAX_W-DATA_W){b_i[DATA_W-1]}}, b_i},
                         DATA_W);
        sum_o  = res_s.sum[DATA_W-1:0];
        clip_o = res_s.clip;
    end

    assign unused_hi_s = ^res_s.sum[SAT_MAX_W-1:DATA_W];
`else
    // Plain two's-complement wrap.
    always_comb begin
        sum_o  = a_i + b_i;
        clip_o = 1'b0;
    end
`endif

endmodule

// File: rtl/acc_tile_buffer.sv
// Partial-sum tile buffer: overwrite pass, accumulate passes, FIFO-order drain.
// Define ACC_SAT_EN for saturating accumulation with a sticky sat_flag.
module acc_tile_buffer
    import acc_tile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LANES  = 2,
    parameter int DEPTH  = 8,
    parameter int LEN_W  = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    start,
    input  logic [LEN_W-1:0]        cfg_len,
    input  logic                    drain_req,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic                    out_last,
    output logic                    busy,
    output logic                    sat_flag
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int VEC_W = LANES * DATA_W;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              pend_q, pend_d;
    logic              sat_q, sat_d;
    logic [VEC_W-1:0]  mem_q [DEPTH];

    logic [LEN_W-1:0]  last_idx_s;
    logic [LEN_W-1:0]  len_clamped_s;
    logic [VEC_W-1:0]  acc_vec_s;
    logic [VEC_W-1:0]  sum_vec_s;
    logic [LANES-1:0]  lane_clip_s;
    logic              wr_en_s;
    logic              pass_end_s;
    logic              rd_last_s;
    logic              sat_set_s;

    assign last_idx_s = len_q - LEN_W'(1);
    assign acc_vec_s  = mem_q[wr_idx_q];
    assign wr_en_s    = in_valid && in_ready;
    assign pass_end_s = wr_en_s && (LEN_W'(wr_idx_q) == last_idx_s);
    assign rd_last_s  = (LEN_W'(rd_idx_q) == last_idx_s);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        acc_lane_add #(.DATA_W(DATA_W)) u_add (
            .a_i    (acc_vec_s[l*DATA_W +: DATA_W]),
            .b_i    (in_data[l*DATA_W +: DATA_W]),
            .sum_o  (sum_vec_s[l*DATA_W +: DATA_W]),
            .clip_o (lane_clip_s[l])
        );
    end

`ifdef ACC_SAT_EN
    assign sat_set_s = wr_en_s && (state_q == ACCUM) && (|lane_clip_s);
`else
    logic unused_clip_s;
    assign unused_clip_s = |lane_clip_s;
    assign sat_set_s     = 1'b0;
`endif

    // Clamp the requested tile length into 1..DEPTH.
    always_comb begin
        if (cfg_len == {LEN_W{1'b0}}) begin
            len_clamped_s = LEN_W'(1);
        end else if (cfg_len > LEN_W'(DEPTH)) begin
            len_clamped_s = LEN_W'(DEPTH);
        end else begin
            len_clamped_s = cfg_len;
        end
    end

    // Next-state logic for the control FSM, indices and flags.
    always_comb begin
        state_d  = state_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        len_d    = len_q;
        pend_d   = pend_q;
        sat_d    = sat_q;
        if (clr) begin
            state_d  = IDLE;
            wr_idx_d = {IDX_W{1'b0}};
            rd_idx_d = {IDX_W{1'b0}};
            pend_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        len_d    = len_clamped_s;
                        sat_d    = 1'b0;
                        wr_idx_d = {IDX_W{1'b0}};
                        pend_d   = 1'b0;
                        state_d  = LOAD;
                    end else begin
                        state_d  = IDLE;
                    end
                end
                LOAD, ACCUM: begin
                    if (sat_set_s) begin
                        sat_d = 1'b1;
                    end else begin
                        sat_d = sat_q;
                    end
                    if (pass_end_s) begin
                        wr_idx_d = {IDX_W{1'b0}};
                    end else if (wr_en_s) begin
                        wr_idx_d = wr_idx_q + IDX_W'(1);
                    end else begin
                        wr_idx_d = wr_idx_q;
                    end
                    // A drain request at an ACCUM pass boundary needs no extra pass.
                    if (pass_end_s) begin
                        if (pend_q || drain_req) begin
                            state_d  = DRAIN;
                            rd_idx_d = {IDX_W{1'b0}};
                            pend_d   = 1'b0;
                        end else begin
                            state_d  = ACCUM;
                        end
                    end else if (drain_req) begin
                        if ((wr_idx_q == {IDX_W{1'b0}}) && (state_q == ACCUM)) begin
                            state_d  = DRAIN;
                            rd_idx_d = {IDX_W{1'b0}};
                            pend_d   = 1'b0;
                        end else begin
                            pend_d   = 1'b1;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (rd_last_s) begin
                            state_d  = IDLE;
                            rd_idx_d = {IDX_W{1'b0}};
                        end else begin
                            rd_idx_d = rd_idx_q + IDX_W'(1);
                        end
                    end else begin
                        rd_idx_d = rd_idx_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_idx_q <= {IDX_W{1'b0}};
            rd_idx_q <= {IDX_W{1'b0}};
            len_q    <= {LEN_W{1'b0}};
            pend_q   <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            len_q    <= len_d;
            pend_q   <= pend_d;
            sat_q    <= sat_d;
        end
    end

    // Tile storage: overwrite on the first pass, accumulate afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {VEC_W{1'b0}};
            end
        end else if (!clr && wr_en_s) begin
            if (state_q == ACCUM) begin
                mem_q[wr_idx_q] <= sum_vec_s;
            end else begin
                mem_q[wr_idx_q] <= in_data;
            end
        end
    end

    assign in_ready  = (state_q == LOAD) || (state_q == ACCUM);
    assign out_valid = (state_q == DRAIN);
    assign out_data  = (state_q == DRAIN) ? mem_q[rd_idx_q] : {VEC_W{1'b0}};
    assign out_last  = (state_q == DRAIN) && rd_last_s;
    assign busy      = (state_q != IDLE);
    assign sat_flag  = sat_q;

endmodule
